axi4_read_buffer: RTL

//  Parametrised AXI4 read-path buffer: decouples upstream master from downstream slave on AR and R.

---
 rtl/axi4_read_buffer_pkg.sv | 24 ++
 rtl/axi4_read_buffer_if.sv | 23 ++
 rtl/axi4_read_buffer_sync_fifo.sv | 55 +++++
 rtl/axi4_read_buffer.sv | 84 ++++++++
 4 files changed

// File: rtl/axi4_read_buffer_pkg.sv
// Shared AXI4 read-channel payload types for the read-path buffer.
// Field order is fixed so that packed payloads stay bit-compatible with the rest of the fabric.
package axi4_read_buffer_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [ID_W-1:0]   Id;
        logic [ADDR_W-1:0] Addr;
        logic [7:0]        Len;
        logic [2:0]        Size;
        logic [1:0]        Burst;
    } AxiRdAddr_t;

    typedef struct packed {
        logic [ID_W-1:0]   Id;
        logic [DATA_W-1:0] Data;
        logic [1:0]        Resp;
        logic              Last;
    } AxiRdData_t;

endpackage

// File: rtl/axi4_read_buffer_if.sv
// AXI4 read-only interface: AR and R channels.
// Master drives AR and accepts R; Slave is the mirror image.
interface AXI4ReadIntf;
    import axi4_read_buffer_pkg::*;

    logic       RdAddrValid;
    logic       RdAddrReady;
    AxiRdAddr_t RdAddrPayload;
    logic       RdDataValid;
    logic       RdDataReady;
    AxiRdData_t RdDataPayload;

    modport Master (
        output RdAddrValid, RdAddrPayload, RdDataReady,
        input  RdAddrReady, RdDataValid, RdDataPayload
    );

    modport Slave (
        input  RdAddrValid, RdAddrPayload, RdDataReady,
        output RdAddrReady, RdDataValid, RdDataPayload
    );

endinterface

// File: rtl/axi4_read_buffer_sync_fifo.sv
// Synchronous FIFO with registered storage and occupancy counter; no fall-through.
// Flags derive only from the level register, so they never depend on this cycle's push/pop.
module sync_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  T                             pushData,
    input  logic                         pop,
    output T                             popData,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH+1);

    T               mem [DEPTH];
    logic [PW-1:0]  wrPtr;
    logic [PW-1:0]  rdPtr;
    logic           doPush;
    logic           doPop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign popData = mem[rdPtr];

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/axi4_read_buffer.sv
// AXI4 read-path buffer: independent AR/R FIFOs plus a cap on bursts in flight downstream.
// Every valid/ready output is a function of registers and rst only.
module axi4_read_buffer
    import axi4_read_buffer_pkg::*;
#(
    parameter int unsigned AR_DEPTH        = 4,
    parameter int unsigned R_DEPTH         = 16,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    AXI4ReadIntf.Slave                             s_rd,
    AXI4ReadIntf.Master                            m_rd,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_cnt,
    output logic [$clog2(AR_DEPTH+1)-1:0]          ar_level,
    output logic [$clog2(R_DEPTH+1)-1:0]           r_level,
    output logic                                   err_spurious_last
);

    localparam int unsigned OCW = $clog2(MAX_OUTSTANDING+1);

    logic       arFull, arEmpty, rFull, rEmpty;
    logic       arPush, arPop, rPush, rPop;
    logic       lastIn, lastDec;
    AxiRdAddr_t arHead;
    AxiRdData_t rHead;

    assign s_rd.RdAddrReady   = !rst && !arFull;
    assign m_rd.RdAddrValid   = !rst && !arEmpty && (outstanding_cnt < OCW'(MAX_OUTSTANDING));
    assign m_rd.RdAddrPayload = arHead;
    assign m_rd.RdDataReady   = !rst && !rFull;
    assign s_rd.RdDataValid   = !rst && !rEmpty;
    assign s_rd.RdDataPayload = rHead;

    assign arPush = s_rd.RdAddrValid && s_rd.RdAddrReady;
    assign arPop  = m_rd.RdAddrValid && m_rd.RdAddrReady;
    assign rPush  = m_rd.RdDataValid && m_rd.RdDataReady;
    assign rPop   = s_rd.RdDataValid && s_rd.RdDataReady;

    sync_fifo #(.T(AxiRdAddr_t), .DEPTH(AR_DEPTH)) arFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (arPush),
        .pushData (s_rd.RdAddrPayload),
        .pop      (arPop),
        .popData  (arHead),
        .full     (arFull),
        .empty    (arEmpty),
        .level    (ar_level)
    );

    sync_fifo #(.T(AxiRdData_t), .DEPTH(R_DEPTH)) rFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rPush),
        .pushData (m_rd.RdDataPayload),
        .pop      (rPop),
        .popData  (rHead),
        .full     (rFull),
        .empty    (rEmpty),
        .level    (r_level)
    );

    // A Last with nothing in flight only flags the error; it never consumes a burst.
    assign lastIn  = rPush && m_rd.RdDataPayload.Last;
    assign lastDec = lastIn && (outstanding_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_cnt   <= '0;
            err_spurious_last <= 1'b0;
        end else begin
            if (arPop && !lastDec) begin
                outstanding_cnt <= outstanding_cnt + 1'b1;
            end else if (!arPop && lastDec) begin
                outstanding_cnt <= outstanding_cnt - 1'b1;
            end
            if (lastIn && (outstanding_cnt == '0)) begin
                err_spurious_last <= 1'b1;
            end
        end
    end

endmodule
